// File: rtl/leaf_out_arbiter.sv
// leaf_out_arbiter: round-robin, credit-aware sharing of one leaf-to-BFT
// output link among NUM_REQ packet requesters. The packet on dout is held
// and re-presented while the BFT signals resend.
module leaf_out_arbiter #(
  parameter int PACKET_BITS  = 49,
  parameter int NUM_REQ      = 4,
  parameter int REQ_BITS     = 2,
  parameter int CREDIT_BITS  = 8,
  parameter int INIT_CREDITS = 64
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ*PACKET_BITS-1:0]   req_pkt,
  input  logic [NUM_REQ-1:0]               req_vld,
  output logic [NUM_REQ-1:0]               req_ack,
  input  logic                             credit_ret_vld,
  input  logic [REQ_BITS-1:0]              credit_ret_id,
  input  logic [CREDIT_BITS-1:0]           credit_ret_cnt,
  input  logic                             resend,
  output logic [PACKET_BITS-1:0]           dout_leaf_interface2bft,
  output logic [REQ_BITS-1:0]              grant_id,
  output logic [NUM_REQ-1:0]               credit_zero
);

  localparam logic [CREDIT_BITS:0]   CREDIT_MAX  = {1'b0, {CREDIT_BITS{1'b1}}};
  localparam logic [CREDIT_BITS:0]   CREDIT_ONE  = {{CREDIT_BITS{1'b0}}, 1'b1};
  localparam logic [CREDIT_BITS-1:0] CREDIT_INIT = CREDIT_BITS'(INIT_CREDITS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [PACKET_BITS-1:0]  dout_q, dout_d;
  logic [REQ_BITS-1:0]     grant_q, grant_d;
  logic [REQ_BITS-1:0]     last_grant_q, last_grant_d;
  logic [CREDIT_BITS-1:0]  credit_q [NUM_REQ];
  logic [CREDIT_BITS-1:0]  credit_d [NUM_REQ];
  logic [NUM_REQ-1:0]      credit_zero_q, credit_zero_d;

  logic [NUM_REQ-1:0]      eligible;
  logic [REQ_BITS-1:0]     cand;
  logic [REQ_BITS-1:0]     winner;
  logic                    found;
  logic                    hold;
  logic                    grant_now;
  logic [CREDIT_BITS:0]    credit_sum;

  // A requester may win only if it is asking and still has downstream space.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_vld[i] && (credit_q[i] != '0);
    end
  end

  // Round-robin search starting just after the previous winner.
  always_comb begin
    cand   = '0;
    winner = '0;
    found  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = REQ_BITS'((int'(last_grant_q) + k) % NUM_REQ);
      if (!found && eligible[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Resend only matters when a real packet is on the link; from idle it is ignored.
  assign hold      = resend && (state_q != S_IDLE);
  assign grant_now = found && !hold;

  // Next-state and output decode: hold the packet, load a new winner, or go idle.
  always_comb begin
    state_d      = state_q;
    dout_d       = dout_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    req_ack      = '0;
    if (hold) begin
      state_d = S_HOLD;
    end else if (found) begin
      state_d                  = S_SEND;
      dout_d                   = req_pkt[int'(winner)*PACKET_BITS +: PACKET_BITS];
      dout_d[PACKET_BITS-1]    = 1'b1;
      grant_d                  = winner;
      last_grant_d             = winner;
      req_ack[winner]          = 1'b1;
    end else begin
      state_d = S_IDLE;
      dout_d  = '0;
    end
    if (!reset) begin
      req_ack = '0;
    end
  end

  // Credit bookkeeping: add returns, subtract one per grant, saturate at the top.
  always_comb begin
    credit_sum    = '0;
    credit_zero_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      credit_sum = {1'b0, credit_q[i]};
      if (credit_ret_vld && (credit_ret_id == REQ_BITS'(i))) begin
        credit_sum = credit_sum + {1'b0, credit_ret_cnt};
      end
      if (grant_now && (winner == REQ_BITS'(i))) begin
        credit_sum = credit_sum - CREDIT_ONE;
      end
      if (credit_sum > CREDIT_MAX) begin
        credit_d[i] = CREDIT_MAX[CREDIT_BITS-1:0];
      end else begin
        credit_d[i] = credit_sum[CREDIT_BITS-1:0];
      end
      credit_zero_d[i] = (credit_d[i] == '0);
    end
  end

  // State, output and credit registers; reset drops any packet in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      dout_q        <= '0;
      grant_q       <= '0;
      last_grant_q  <= REQ_BITS'(NUM_REQ - 1);
      credit_zero_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        credit_q[i] <= CREDIT_INIT;
      end
    end else begin
      state_q       <= state_d;
      dout_q        <= dout_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      credit_zero_q <= credit_zero_d;
      for (int i = 0; i < NUM_REQ; i++) begin
        credit_q[i] <= credit_d[i];
      end
    end
  end

  assign dout_leaf_interface2bft = dout_q;
  assign grant_id                = grant_q;
  assign credit_zero             = credit_zero_q;

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Testbench for leaf_out_arbiter: directed scenarios plus randomized traffic
// checked against a queue/array reference model through a scoreboard.
module tb_leaf_out_arbiter;

  localparam int PB   = 49;
  localparam int NR   = 4;
  localparam int RB   = 2;
  localparam int CB   = 8;
  localparam int INIT = 64;
  localparam int CMAX = 255;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NR*PB-1:0]     req_pkt;
  logic [NR-1:0]        req_vld;
  logic [NR-1:0]        req_ack;
  logic                 credit_ret_vld;
  logic [RB-1:0]        credit_ret_id;
  logic [CB-1:0]        credit_ret_cnt;
  logic                 resend;
  logic [PB-1:0]        dout;
  logic [RB-1:0]        grant_id;
  logic [NR-1:0]        credit_zero;

  leaf_out_arbiter #(
    .PACKET_BITS (PB),
    .NUM_REQ     (NR),
    .REQ_BITS    (RB),
    .CREDIT_BITS (CB),
    .INIT_CREDITS(INIT)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .req_pkt                (req_pkt),
    .req_vld                (req_vld),
    .req_ack                (req_ack),
    .credit_ret_vld         (credit_ret_vld),
    .credit_ret_id          (credit_ret_id),
    .credit_ret_cnt         (credit_ret_cnt),
    .resend                 (resend),
    .dout_leaf_interface2bft(dout),
    .grant_id               (grant_id),
    .credit_zero            (credit_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PB-1:0] dout;
    logic [RB-1:0] gid;
    logic [NR-1:0] czero;
  } exp_t;

  exp_t          expQ[$];
  int            checks   = 0;
  int            failures = 0;
  bit            monitorEn = 1'b0;

  // reference model: plain integers and the packet currently on the link
  int            mCredit[NR];
  int            mLast;
  logic [PB-1:0] mDout;
  logic [RB-1:0] mGid;

  logic [PB-1:0] pkt[NR];
  logic [NR-1:0] lastExpAck;
  logic [NR-1:0] lastDutAck;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [PB-1:0] randPkt();
    return PB'({$urandom(), $urandom()});
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NR; i++) mCredit[i] = INIT;
    mLast = NR - 1;
    mDout = '0;
    mGid  = '0;
  endtask

  // Drive one cycle of inputs (called at a falling edge), check the combinational
  // ack against the model, queue the expected registered outputs, advance the model.
  task automatic applyStimulus(input logic [NR-1:0] v, input bit rs, input bit rv,
                               input int rid, input int rcnt);
    int            win;
    int            c;
    bit            holding;
    logic [NR-1:0] expAck;
    exp_t          e;
    for (int i = 0; i < NR; i++) req_pkt[i*PB +: PB] = pkt[i];
    req_vld        = v;
    resend         = rs;
    credit_ret_vld = rv;
    credit_ret_id  = RB'(rid);
    credit_ret_cnt = CB'(rcnt);
    #1;
    win     = -1;
    expAck  = '0;
    holding = rs && mDout[PB-1];
    if (!holding) begin
      for (int k = 1; k <= NR; k++) begin
        int idx;
        idx = (mLast + k) % NR;
        if (win < 0 && v[idx] && mCredit[idx] > 0) win = idx;
      end
    end
    if (win >= 0) expAck[win] = 1'b1;
    checkOutput("req_ack", 64'(req_ack), 64'(expAck));
    lastDutAck = req_ack;
    lastExpAck = expAck;
    for (int i = 0; i < NR; i++) begin
      c = mCredit[i];
      if (rv && rid == i) c = c + rcnt;
      if (win == i) c = c - 1;
      if (c > CMAX) c = CMAX;
      mCredit[i] = c;
    end
    if (!holding) begin
      if (win >= 0) begin
        mDout         = pkt[win];
        mDout[PB-1]   = 1'b1;
        mGid          = RB'(win);
        mLast         = win;
      end else begin
        mDout = '0;
      end
    end
    e.dout = mDout;
    e.gid  = mGid;
    for (int i = 0; i < NR; i++) e.czero[i] = (mCredit[i] == 0);
    expQ.push_back(e);
    @(negedge clk);
  endtask

  // One requester asking alone for a number of cycles; returns how many acks it got.
  task automatic runAlone(input int who, input int cycles, output int acks);
    acks = 0;
    for (int n = 0; n < cycles; n++) begin
      applyStimulus(NR'(1) << who, 1'b0, 1'b0, 0, 0);
      if (lastDutAck[who]) acks++;
      if (lastExpAck[who]) pkt[who] = randPkt();
    end
  endtask

  // Scoreboard monitor: after every rising edge compare the registered outputs
  // with the oldest expectation queued by the stimulus side.
  always @(posedge clk) begin
    #2;
    if (monitorEn) begin
      if (expQ.size() == 0) begin
        checkOutput("scoreboard_underflow", 64'(1), 64'(0));
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("dout", 64'(dout), 64'(e.dout));
        checkOutput("grant_id", 64'(grant_id), 64'(e.gid));
        checkOutput("credit_zero", 64'(credit_zero), 64'(e.czero));
      end
    end
  end

  // Watchdog so the run always ends even if something stalls.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acks;
    logic [NR-1:0] v;
    bit rs, rv;
    int rid, rcnt;

    reset          = 1'b0;
    req_pkt        = '0;
    req_vld        = '0;
    resend         = 1'b0;
    credit_ret_vld = 1'b0;
    credit_ret_id  = '0;
    credit_ret_cnt = '0;
    lastExpAck     = '0;
    lastDutAck     = '0;
    for (int i = 0; i < NR; i++) pkt[i] = '0;
    modelReset();

    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("reset_dout", 64'(dout), 64'(0));
    checkOutput("reset_grant_id", 64'(grant_id), 64'(0));
    checkOutput("reset_credit_zero", 64'(credit_zero), 64'(0));
    @(negedge clk);
    monitorEn = 1'b1;

    $display("[TB] idle cycles");
    repeat (5) applyStimulus(4'b0000, 1'b0, 1'b0, 0, 0);

    $display("[TB] all requesters, fixed payloads");
    for (int i = 0; i < NR; i++) pkt[i] = PB'(32'hA0 + i);
    repeat (8) applyStimulus(4'b1111, 1'b0, 1'b0, 0, 0);

    $display("[TB] requester 2 with resend");
    pkt[2] = randPkt();
    applyStimulus(4'b0100, 1'b0, 1'b0, 0, 0);
    pkt[2] = randPkt();
    repeat (3) applyStimulus(4'b0100, 1'b1, 1'b0, 0, 0);
    applyStimulus(4'b0100, 1'b0, 1'b0, 0, 0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 0, 0);

    $display("[TB] requester 1 until credits run out");
    runAlone(1, 70, acks);
    checkOutput("req1_grants_to_zero", 64'(acks), 64'(62));
    checkOutput("req1_credit_zero", 64'(credit_zero[1]), 64'(1));
    applyStimulus(4'b0010, 1'b0, 1'b1, 1, 5);
    checkOutput("req1_ack_on_return_cycle", 64'(lastDutAck[1]), 64'(0));
    runAlone(1, 10, acks);
    checkOutput("req1_resumed_grants", 64'(acks), 64'(5));

    $display("[TB] requester 0 same-cycle return and saturation");
    runAlone(0, 52, acks);
    checkOutput("req0_grants_to_10", 64'(acks), 64'(52));
    applyStimulus(4'b0001, 1'b0, 1'b1, 0, 3);
    checkOutput("req0_ack_with_return", 64'(lastDutAck[0]), 64'(1));
    pkt[0] = randPkt();
    runAlone(0, 20, acks);
    checkOutput("req0_grants_after_net_12", 64'(acks), 64'(12));
    applyStimulus(4'b0000, 1'b0, 1'b1, 0, 200);
    applyStimulus(4'b0000, 1'b0, 1'b1, 0, 255);
    runAlone(0, 270, acks);
    checkOutput("req0_grants_saturated", 64'(acks), 64'(255));

    $display("[TB] randomized traffic");
    v = '0;
    for (int i = 0; i < NR; i++) pkt[i] = randPkt();
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NR; i++) begin
        if (!v[i] || lastExpAck[i]) begin
          pkt[i] = randPkt();
          v[i]   = ($urandom_range(0, 3) != 0);
        end else if ($urandom_range(0, 15) == 0) begin
          v[i] = 1'b0;
        end
      end
      rs   = ($urandom_range(0, 3) == 0);
      rv   = ($urandom_range(0, 7) == 0);
      rid  = int'($urandom_range(0, NR - 1));
      rcnt = ($urandom_range(0, 31) == 0) ? int'($urandom_range(100, 255))
                                          : int'($urandom_range(0, 3));
      applyStimulus(v, rs, rv, rid, rcnt);
    end

    $display("[TB] reset while holding");
    pkt[2] = randPkt();
    applyStimulus(4'b0100, 1'b0, 1'b0, 0, 0);
    applyStimulus(4'b0101, 1'b1, 1'b0, 0, 0);
    monitorEn = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_reset_dout", 64'(dout), 64'(0));
    checkOutput("async_reset_grant_id", 64'(grant_id), 64'(0));
    checkOutput("async_reset_req_ack", 64'(req_ack), 64'(0));
    expQ.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    modelReset();
    monitorEn = 1'b1;
    for (int i = 0; i < NR; i++) pkt[i] = randPkt();
    applyStimulus(4'b1111, 1'b0, 1'b0, 0, 0);
    checkOutput("post_reset_first_priority", 64'(lastDutAck), 64'(4'b0001));
    runAlone(3, 70, acks);
    checkOutput("post_reset_credits", 64'(acks), 64'(64));

    monitorEn = 1'b0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
